// File: rtl/scalar_add_pkg.sv
// scalar_add_pkg
//   Types and constants shared by the scalar-add feeder and its pair FIFO.
//   DATA_W_DEFAULT : default operand width.
//   feeder_state_t : GET_A (no word held) / GET_B (A word held).
//   pair_t         : operand pair {a, b} at the default width. The feeder
//                    declares the same layout at its own DATA_W.
package scalar_add_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    GET_A = 1'b0,
    GET_B = 1'b1
  } feeder_state_t;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] a;
    logic [DATA_W_DEFAULT-1:0] b;
  } pair_t;

endpackage

// File: rtl/scalar_add_pair_fifo.sv
// scalar_add_pair_fifo
//   Circular buffer of operand pairs. DEPTH must be a power of two and at
//   least 2, so the pointers wrap by plain overflow.
//   Ports:
//     clock, reset       : clock and async active-high reset
//     push, push_data    : write one pair (ignored when full)
//     pop                : drop the head pair (ignored when empty)
//     pop_data           : head pair, zero while empty
//     full, empty        : occupancy == DEPTH / occupancy == 0
module scalar_add_pair_fifo #(
  parameter int  DEPTH  = 2,
  parameter type pair_t = scalar_add_pkg::pair_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  pair_t push_data,
  input  logic  pop,
  output pair_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Gate the head with empty so the outputs read zero in and after reset
  // without needing to clear the storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scalar_add_feeder.sv
// scalar_add_feeder
//   Groups a word stream into operand pairs (A, B) for an adder stage.
//   A stream with an odd word count ends with (last_word, 0) when in_last
//   is seen while no A word is held. Pairs are buffered in a DEPTH-entry
//   FIFO; the op side is driven from FIFO state only (one-cycle latency,
//   no combinational in->op path).
//   Ports:
//     clock, reset                 : clock, async active-high reset
//     in_valid/in_ready/in_data/in_last : word input handshake
//     op_valid/op_ready/op_a/op_b  : pair output handshake
//     busy                         : A word held or FIFO non-empty
//     pair_count                   : pair transfers, wraps at 2^32
//                                    (only with SCALAR_ADD_FEEDER_STATS_EN)
//   Build option: define SCALAR_ADD_FEEDER_STATS_EN to add pair_count.
module scalar_add_feeder
  import scalar_add_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              busy
`ifdef SCALAR_ADD_FEEDER_STATS_EN
  ,
  output logic [31:0]       pair_count
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } word_pair_t;

  feeder_state_t     state, state_nxt;
  logic [DATA_W-1:0] a_q, a_nxt;
  logic              push;
  word_pair_t        push_pair;
  word_pair_t        head;
  logic              full, empty;
  logic              in_xfer, op_xfer;

  // Reset gates in_ready directly so it reads 0 for the whole reset pulse.
  assign in_ready = ~full & ~reset;
  assign in_xfer  = in_valid & in_ready;
  assign op_valid = ~empty;
  assign op_xfer  = op_valid & op_ready;
  assign op_a     = head.a;
  assign op_b     = head.b;
  assign busy     = (state == GET_B) | ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= GET_A;
      a_q   <= '0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_q;
    push        = 1'b0;
    push_pair.a = a_q;
    push_pair.b = in_data;
    case (state)
      GET_A: begin
        if (in_xfer) begin
          if (in_last) begin
            // Odd tail: pad the missing B operand with zero.
            push        = 1'b1;
            push_pair.a = in_data;
            push_pair.b = '0;
          end else begin
            a_nxt     = in_data;
            state_nxt = GET_B;
          end
        end
      end
      GET_B: begin
        // in_last is irrelevant here: the pair is complete either way.
        if (in_xfer) begin
          push      = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
  end

  scalar_add_pair_fifo #(
    .DEPTH  (DEPTH),
    .pair_t (word_pair_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_pair),
    .pop       (op_xfer),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef SCALAR_ADD_FEEDER_STATS_EN
  logic [31:0] pair_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        pair_count_q <= '0;
    else if (op_xfer) pair_count_q <= pair_count_q + 32'd1;
  end

  assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_scalar_add_feeder.sv
module tb_scalar_add_feeder;
  import scalar_add_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
`ifdef SCALAR_ADD_FEEDER_STATS_EN
  logic [31:0] pair_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  scalar_add_feeder #(.DATA_W(32), .DEPTH(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy)
`ifdef SCALAR_ADD_FEEDER_STATS_EN
    ,
    .pair_count (pair_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this are seen at the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic word(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    op_ready = 1'b0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_state", 32'(dut.state), 32'(GET_A));
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Two-word stream 3,5
    op_ready = 1'b1;
    word(3, 1'b0);
    tick();
    check("w3_op_valid", 32'(op_valid), 0);
    check("w3_busy", 32'(busy), 1);
    word(5, 1'b1);
    tick();
    idle();
    check("p35_valid", 32'(op_valid), 1);
    check("p35_a", op_a, 3);
    check("p35_b", op_b, 5);
    tick();
    check("p35_one_cycle", 32'(op_valid), 0);
    check("p35_busy_after", 32'(busy), 0);

    // Single word 7 with in_last -> (7,0)
    word(7, 1'b1);
    tick();
    idle();
    check("p70_valid", 32'(op_valid), 1);
    check("p70_a", op_a, 7);
    check("p70_b", op_b, 0);
    check("p70_state", 32'(dut.state), 32'(GET_A));
    tick();
    check("p70_drained", 32'(busy), 0);

    // Backpressure: words 1..6 with op_ready low
    op_ready = 1'b0;
    word(1, 1'b0); tick();
    word(2, 1'b0); tick();
    check("bp_p12_valid", 32'(op_valid), 1);
    check("bp_ready_after2", 32'(in_ready), 1);
    word(3, 1'b0); tick();
    word(4, 1'b0); tick();
    check("bp_full_ready", 32'(in_ready), 0);
    word(5, 1'b0); tick();
    check("bp_hold_ready", 32'(in_ready), 0);
    check("bp_hold_a", op_a, 1);
    check("bp_hold_b", op_b, 2);
    tick();
    check("bp_hold2_a", op_a, 1);
    check("bp_hold2_b", op_b, 2);
    op_ready = 1'b1;
    tick();
    check("bp_p34_a", op_a, 3);
    check("bp_p34_b", op_b, 4);
    check("bp_ready_again", 32'(in_ready), 1);
    tick();
    check("bp_w5_held_valid", 32'(op_valid), 0);
    check("bp_w5_busy", 32'(busy), 1);
    word(6, 1'b0); tick();
    idle();
    check("bp_p56_valid", 32'(op_valid), 1);
    check("bp_p56_a", op_a, 5);
    check("bp_p56_b", op_b, 6);
    tick();
    check("bp_drained", 32'(busy), 0);

    // Streaming 1..8 with op_ready high
    for (int i = 1; i <= 8; i++) begin
      word(32'(i), 1'b0);
      tick();
      if (i % 2 == 0) begin
        check($sformatf("st_valid_%0d", i), 32'(op_valid), 1);
        check($sformatf("st_a_%0d", i), op_a, 32'(i - 1));
        check($sformatf("st_b_%0d", i), op_b, 32'(i));
      end else begin
        check($sformatf("st_gap_%0d", i), 32'(op_valid), 0);
      end
    end
    idle();
    tick();
    check("st_drained", 32'(op_valid), 0);

    // Reset mid-operation: pair (1,2) queued, 9 held as A
    op_ready = 1'b0;
    word(1, 1'b0); tick();
    word(2, 1'b0); tick();
    word(9, 1'b0); tick();
    idle();
    check("mid_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_op_valid", 32'(op_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    tick();
    reset = 1'b0;
    op_ready = 1'b1;
    word(2, 1'b0); tick();
    check("mid_no_stale_pair", 32'(op_valid), 0);
    word(4, 1'b0); tick();
    idle();
    check("mid_p24_valid", 32'(op_valid), 1);
    check("mid_p24_a", op_a, 2);
    check("mid_p24_b", op_b, 4);
    tick();
    check("mid_done_valid", 32'(op_valid), 0);
    check("mid_done_busy", 32'(busy), 0);

`ifdef SCALAR_ADD_FEEDER_STATS_EN
    // Counter wrap
    force dut.pair_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.pair_count_q;
    check("cnt_preload", pair_count, 32'hFFFF_FFFE);
    word(1, 1'b1); tick();
    word(2, 1'b1); tick();
    idle();
    check("cnt_ffffffff", pair_count, 32'hFFFF_FFFF);
    tick();
    check("cnt_wrap", pair_count, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scalar_add_feeder.md
SCALAR_ADD_FEEDER -- requirements
Module: scalar_add_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the operand and word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, the pair-FIFO depth in entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, ports as follows.
REQ-004 clock  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  upstream word valid.
REQ-007 in_ready  out  1  feeder can accept a word.
REQ-008 in_data  in  DATA_W  upstream word.
REQ-009 in_last  in  1  marks the final word of a stream.
REQ-010 op_valid  out  1  operand pair available to the adder stage.
REQ-011 op_ready  in  1  adder stage takes the pair.
REQ-012 op_a  out  DATA_W  first operand of the head pair.
REQ-013 op_b  out  DATA_W  second operand of the head pair.
REQ-014 busy  out  1  high when a held A word exists or the FIFO is non-empty.

Function
REQ-015 Word transfer SHALL occur on a rising edge with in_valid and in_ready both high; pair transfer SHALL occur with op_valid and op_ready both high.
REQ-016 FSM states SHALL be GET_A (no held word) and GET_B (A word held).
REQ-017 GET_A with a transfer and in_last=0 SHALL store in_data as A and go to GET_B.
REQ-018 GET_A with a transfer and in_last=1 SHALL push pair (in_data, 0) and stay in GET_A.
REQ-019 GET_B with a transfer SHALL push pair (A, in_data), ignore in_last, and go to GET_A.
REQ-020 in_ready SHALL equal NOT fifo_full in both states; there is no same-cycle pop-to-push bypass.
REQ-021 op_valid SHALL equal NOT fifo_empty; op_a and op_b SHALL show the head entry, stable while op_valid is high and op_ready is low.
REQ-022 Latency: a pair pushed at edge N SHALL appear with op_valid=1 after edge N, with no combinational in-to-op path.
REQ-023 A simultaneous push and pop SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-024 Pointers SHALL wrap modulo DEPTH; full means occupancy equals DEPTH, and empty means occupancy is 0.
REQ-025 Data SHALL pass unmodified; the feeder performs no arithmetic on operands.

Reset
REQ-026 While reset is high: in_ready=0, op_valid=0, busy=0, state=GET_A, FIFO empty; op_a and op_b are 0.
REQ-027 Reset mid-operation SHALL discard the held A word and all FIFO pairs; no pair is emitted after reset release.
REQ-028 On the first edge after reset release, in_ready SHALL be 1.

Configuration
REQ-029 Macro SCALAR_ADD_FEEDER_STATS_EN defined SHALL add output pair_count (out, 32), counting pair transfers, reset to 0, wrapping from 0xFFFFFFFF to 0.
REQ-030 Macro SCALAR_ADD_FEEDER_STATS_EN undefined SHALL remove the pair_count port and counter entirely; all other behaviour is identical.

Structure
REQ-031 Shared package scalar_add_pkg SHALL hold the DATA_W default constant, the feeder state enum (GET_A, GET_B), and the pair struct {a, b}.
REQ-032 Sub-module scalar_add_pair_fifo (parameters DEPTH and pair type, push/pop/full/empty) SHALL implement the buffer; the FSM lives in scalar_add_feeder.

Verification
REQ-033 Words 3, 5 with in_last on 5 and op_ready=1 -> one pair a=3, b=5, op_valid high for exactly one cycle.
REQ-034 Single word 7 with in_last=1 -> pair a=7, b=0; the state returns to GET_A.
REQ-035 With op_ready=0, DEPTH=2, push words 1..6 -> in_ready drops after 4 words; the pairs (1,2),(3,4) are held stable; raising op_ready drains them in order, then (5,6) follows.
REQ-036 Continuous in_valid and op_ready=1 with words 1..8 -> pairs (1,2),(3,4),(5,6),(7,8) with no bubbles beyond the 1-cycle latency.
REQ-037 Assert reset after word 9 is taken in GET_B with one pair queued -> op_valid=0 and busy=0 immediately; after release, words 2, 4 -> pair (2,4) only.
REQ-038 With SCALAR_ADD_FEEDER_STATS_EN, preload the counter at 0xFFFFFFFE via a force, then send 2 pairs -> pair_count reads 0xFFFFFFFF, then 0.
